// File: rtl/norm_sumsq.sv
// Sum-of-squares front end for the normalization datapath.
// Accumulates N signed samples, saturates to 16 bits, hands off to sqrt.
module norm_sumsq #(
  parameter int N  = 4,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          start,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic [15:0]   sq_sum,
  output logic          go,
  input  logic          sqrt_done,
  output logic          busy,
  output logic          sat,
  output logic          frame_done
);

  localparam int AW = 2*DW + $clog2(N) + 1;
  localparam int EW = (AW > 16) ? AW : 17;
  localparam int CW = $clog2(N+1);

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    ISSUE,
    WAIT
  } state_t;

  state_t              state;
  state_t              state_nx;
  logic [AW-1:0]       acc;
  logic [CW-1:0]       cnt;
  logic signed [2*DW-1:0] sx;
  logic [2*DW-1:0]     sq;
  logic [AW-1:0]       sum;
  logic [EW-1:0]       sum_x;
  logic                xfer;
  logic                last;
  logic                ovf;

  assign sx    = {{DW{in_data[DW-1]}}, in_data};
  assign sq    = sx * sx;
  assign sum   = acc + AW'(sq);
  assign sum_x = EW'(sum);
  assign ovf   = |sum_x[EW-1:16];
  assign last  = (cnt == CW'(N-1));
  assign xfer  = in_valid && in_ready;

  assign in_ready = (state == ACC);
  assign go       = (state == ISSUE);
  assign busy     = (state != IDLE);

  // state register
  always_ff @(posedge clk) begin
    if (clr) state <= IDLE;
    else     state <= state_nx;
  end

  // next-state decode; stray start/sqrt_done are ignored outside their state
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = ACC;
      ACC:     if (xfer && last) state_nx = ISSUE;
      ISSUE:   state_nx = WAIT;
      WAIT:    if (sqrt_done) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // accumulator, count, saturated result and done pulse
  always_ff @(posedge clk) begin
    if (clr) begin
      acc        <= '0;
      cnt        <= '0;
      sq_sum     <= '0;
      sat        <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= (state == WAIT) && sqrt_done;
      unique case (state)
        IDLE: begin
          if (start) begin
            acc <= '0;
            cnt <= '0;
            sat <= 1'b0;
          end
        end
        ACC: begin
          if (xfer) begin
            acc <= sum;
            cnt <= cnt + 1'b1;
            if (last) begin
              sq_sum <= ovf ? 16'hFFFF : sum_x[15:0];
              sat    <= ovf;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_norm_sumsq.sv
// Directed bench for norm_sumsq (N=4, DW=8).
// Inputs change and outputs are checked 1 time unit after each rising edge.
module tb_norm_sumsq;

  logic        clk = 1'b0;
  logic        clr;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic [15:0] sq_sum;
  logic        go;
  logic        sqrt_done;
  logic        busy;
  logic        sat;
  logic        frame_done;

  int tests = 0;
  int fails = 0;
  int go_cnt = 0;
  int exp_go = 0;

  norm_sumsq #(.N(4), .DW(8)) dut (
    .clk        (clk),
    .clr        (clr),
    .start      (start),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .sq_sum     (sq_sum),
    .go         (go),
    .sqrt_done  (sqrt_done),
    .busy       (busy),
    .sat        (sat),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (go === 1'b1) go_cnt <= go_cnt + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
    in_data  = 8'h00;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic done_strobe();
    sqrt_done = 1'b1;
    tick();
    sqrt_done = 1'b0;
  endtask

  initial begin
    clr = 1'b1; start = 1'b0; in_valid = 1'b0;
    in_data = 8'h00; sqrt_done = 1'b0;
    tick(); tick();
    clr = 1'b0;

    // reset state
    check("rst_in_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_go", go, 0);
    check("rst_sq_sum", sq_sum, 0);
    check("rst_sat", sat, 0);
    check("rst_frame_done", frame_done, 0);

    // frame 1: 3,-4,0,12 -> 169
    do_start();
    check("f1_in_ready", in_ready, 1);
    check("f1_busy", busy, 1);
    push(8'd3); push(8'hFC); push(8'd0);
    check("f1_no_go_early", go, 0);
    push(8'd12);
    exp_go++;
    check("f1_go", go, 1);
    check("f1_sq_sum", sq_sum, 16'h00A9);
    check("f1_sat", sat, 0);
    check("f1_issue_ready", in_ready, 0);
    tick();
    check("f1_go_drop", go, 0);
    check("f1_wait_busy", busy, 1);
    for (int i = 0; i < 9; i++) tick();
    check("f1_no_fd_yet", frame_done, 0);
    done_strobe();
    check("f1_frame_done", frame_done, 1);
    check("f1_busy_drop", busy, 0);
    check("f1_hold", sq_sum, 16'h00A9);
    tick();
    check("f1_fd_pulse", frame_done, 0);

    // frame 2: -128 x4 -> saturate
    do_start();
    check("f2_sat_cleared", sat, 0);
    for (int i = 0; i < 4; i++) push(8'h80);
    exp_go++;
    check("f2_go", go, 1);
    check("f2_sq_sum", sq_sum, 16'hFFFF);
    check("f2_sat", sat, 1);
    tick();
    done_strobe();
    check("f2_frame_done", frame_done, 1);
    check("f2_sat_hold", sat, 1);
    tick();

    // frame 3: 127 x4 -> 64516
    do_start();
    for (int i = 0; i < 4; i++) push(8'd127);
    exp_go++;
    check("f3_sq_sum", sq_sum, 16'hFC04);
    check("f3_sat", sat, 0);
    tick();
    done_strobe();
    tick();

    // frame 4: gapped in_valid
    do_start();
    in_data = 8'd1; in_valid = 1'b1;
    check("f4_ready0", in_ready, 1); tick();
    in_data = 8'd55; in_valid = 1'b0;
    check("f4_ready1", in_ready, 1); tick();
    check("f4_ready2", in_ready, 1); tick();
    in_data = 8'd2; in_valid = 1'b1;
    check("f4_ready3", in_ready, 1); tick();
    in_data = 8'd55; in_valid = 1'b0;
    check("f4_ready4", in_ready, 1); tick();
    in_data = 8'd3; in_valid = 1'b1;
    check("f4_ready5", in_ready, 1); tick();
    in_data = 8'd4;
    check("f4_ready6", in_ready, 1); tick();
    in_valid = 1'b0;
    exp_go++;
    check("f4_go", go, 1);
    check("f4_sq_sum", sq_sum, 30);
    tick();
    done_strobe();
    tick();

    // frame 5: stray sqrt_done in ACC, stray start in WAIT
    do_start();
    push(8'd1);
    done_strobe();
    check("f5_acc_busy", busy, 1);
    check("f5_acc_ready", in_ready, 1);
    check("f5_acc_no_fd", frame_done, 0);
    push(8'd2); push(8'd2); push(8'hFE);
    exp_go++;
    check("f5_go", go, 1);
    check("f5_sq_sum", sq_sum, 13);
    tick();
    do_start();
    check("f5_wait_busy", busy, 1);
    check("f5_wait_ready", in_ready, 0);
    check("f5_wait_go", go, 0);
    done_strobe();
    check("f5_frame_done", frame_done, 1);
    check("f5_hold", sq_sum, 13);
    tick();

    // clr in WAIT
    do_start();
    for (int i = 0; i < 4; i++) push(8'd5);
    exp_go++;
    check("f6_sq_sum", sq_sum, 100);
    tick();
    clr = 1'b1; tick(); clr = 1'b0;
    check("clr_sq_sum", sq_sum, 0);
    check("clr_busy", busy, 0);
    check("clr_sat", sat, 0);
    done_strobe();
    check("clr_no_fd", frame_done, 0);
    check("clr_idle", busy, 0);

    // clr in ACC: no go for the aborted vector
    do_start();
    push(8'd7);
    clr = 1'b1; start = 1'b1; tick();
    clr = 1'b0; start = 1'b0;
    check("clr_win_busy", busy, 0);
    tick(); tick();
    check("clr_acc_go", go, 0);
    check("go_count_abort", go_cnt, exp_go);

    // 1,1,1,1 -> 4
    do_start();
    for (int i = 0; i < 4; i++) push(8'd1);
    exp_go++;
    check("f7_sq_sum", sq_sum, 4);
    tick();

    // back-to-back start in the frame_done cycle
    done_strobe();
    check("b2b_fd", frame_done, 1);
    start = 1'b1; tick(); start = 1'b0;
    check("b2b_ready", in_ready, 1);
    check("b2b_hold0", sq_sum, 4);
    push(8'd2); push(8'd2); push(8'd2);
    check("b2b_hold1", sq_sum, 4);
    push(8'd2);
    exp_go++;
    check("b2b_go", go, 1);
    check("b2b_sq_sum", sq_sum, 16);
    tick();
    check("go_count", go_cnt, exp_go);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
